notification_tx_packer: RTL and testbench

- Return path of the UART configuration link.
- Collects the notification, error and VGA-notification pulses that the colour manager produces, and buffers one pending event per source.
- Arbitrates among pending events by fixed priority and packs each into a tagged 8-bit byte.
- Writes the bytes into the UART transmit FIFO using a write-enable/full handshake, so the host receives the responses to the commands it sent.

---
 rtl/notification_tx_packer.sv | 184 ++++++++++++++++++
 tb/tb_notification_tx_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/notification_tx_packer.sv
// rtl/notification_tx_packer.sv - packs colour-manager event pulses into tagged bytes for the UART TX FIFO
//
// Purpose: holds one pending event per source (error, config notification,
// VGA notification) and sends them by fixed priority (error > config > VGA).
// Each event becomes one byte {tag[1:0], payload zero-extended to 6 bits}.
// Bytes go to the TX FIFO over a Wr_En/Full handshake.
//
// Optional feature: define NOTIF_HEARTBEAT_EN to send a heartbeat byte
// {2'b00, Config_Status} after HEARTBEAT_PERIOD idle cycles. This byte has the
// lowest priority.
//
// Ports:
//   Clk                        system clock, rising edge
//   rst_n                      synchronous reset, active-high (1 = reset)
//   Config_Notification(_Valid) config notification payload / one-cycle qualifier
//   Config_Error, Error_Valid  config error payload / one-cycle qualifier
//   VGA_Notification(_Valid)   VGA notification payload / one-cycle qualifier
//   Config_Status              status carried by heartbeat bytes
//   Full                       TX FIFO full
//   TXD_Data                   byte presented to the TX FIFO
//   Wr_En                      TX FIFO write request
//   Busy                       any slot pending or a byte in flight
//   Drop_Count                 saturating count of overwritten, unsent events
module notification_tx_packer #(
  parameter int UART_DATA_WIDTH           = 8,
  parameter int CONFIG_NOTIFICATION_WIDTH = 4,
  parameter int CONFIG_ERROR_WIDTH        = 4,
  parameter int VGA_NOTIFICATION_WIDTH    = 4,
  parameter int CONFIG_STATUS_WIDTH       = 4,
  parameter int HEARTBEAT_PERIOD          = 1000
) (
  input  logic                                 Clk,
  input  logic                                 rst_n,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  input  logic                                 VGA_Notification_Valid,
  input  logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
  input  logic                                 Full,
  output logic [UART_DATA_WIDTH-1:0]           TXD_Data,
  output logic                                 Wr_En,
  output logic                                 Busy,
  output logic [7:0]                           Drop_Count
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t state_q, state_d;

  logic                                 pend_err_q, pend_cfg_q, pend_vga_q;
  logic [CONFIG_ERROR_WIDTH-1:0]        pay_err_q;
  logic [CONFIG_NOTIFICATION_WIDTH-1:0] pay_cfg_q;
  logic [VGA_NOTIFICATION_WIDTH-1:0]    pay_vga_q;

  logic                       any_pend;
  logic                       load_err, load_cfg, load_vga;
  logic                       hb_fire;
  logic [UART_DATA_WIDTH-1:0] txd_q, txd_d;
  logic [7:0]                 drop_q;
  logic                       drop_err, drop_cfg, drop_vga;
  logic [1:0]                 drop_sum;
  logic [9:0]                 drop_next;
  logic [UART_DATA_WIDTH-1:0] hb_byte;

  assign any_pend = pend_err_q | pend_cfg_q | pend_vga_q;

`ifdef NOTIF_HEARTBEAT_EN
  logic [15:0] idle_cnt_q;

  // Fires only on an idle edge with no pend, so real events always pre-empt it.
  assign hb_fire = (state_q == ST_IDLE) && !any_pend &&
                   (idle_cnt_q == 16'(HEARTBEAT_PERIOD - 1));
  assign hb_byte = UART_DATA_WIDTH'({2'b00, 6'(Config_Status)});

  always_ff @(posedge Clk) begin
    if (rst_n) begin
      idle_cnt_q <= 16'd0;
    end else if ((state_q == ST_IDLE) && !any_pend && !hb_fire) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end else begin
      idle_cnt_q <= 16'd0;
    end
  end
`else
  localparam int unused_hb_period = HEARTBEAT_PERIOD;
  logic unused_status;

  assign unused_status = ^Config_Status;
  assign hb_fire       = 1'b0;
  assign hb_byte       = '0;
`endif

  // Next-state / byte selection. A slot is only loaded from IDLE, so a byte in
  // SEND stays stable until the FIFO accepts it.
  always_comb begin
    state_d  = state_q;
    txd_d    = txd_q;
    load_err = 1'b0;
    load_cfg = 1'b0;
    load_vga = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_err_q) begin
          load_err = 1'b1;
          txd_d    = UART_DATA_WIDTH'({2'b10, 6'(pay_err_q)});
          state_d  = ST_SEND;
        end else if (pend_cfg_q) begin
          load_cfg = 1'b1;
          txd_d    = UART_DATA_WIDTH'({2'b01, 6'(pay_cfg_q)});
          state_d  = ST_SEND;
        end else if (pend_vga_q) begin
          load_vga = 1'b1;
          txd_d    = UART_DATA_WIDTH'({2'b11, 6'(pay_vga_q)});
          state_d  = ST_SEND;
        end else if (hb_fire) begin
          txd_d    = hb_byte;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!Full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
    end
  end

  // A new valid on a slot that is loaded on the same edge re-arms the slot.
  // That case is not a drop, because the old payload has just been sent on.
  assign drop_err  = Error_Valid               & pend_err_q & ~load_err;
  assign drop_cfg  = Config_Notification_Valid & pend_cfg_q & ~load_cfg;
  assign drop_vga  = VGA_Notification_Valid    & pend_vga_q & ~load_vga;
  assign drop_sum  = 2'(drop_err) + 2'(drop_cfg) + 2'(drop_vga);
  assign drop_next = {2'b00, drop_q} + 10'(drop_sum);

  always_ff @(posedge Clk) begin
    if (rst_n) begin
      pend_err_q <= 1'b0;
      pend_cfg_q <= 1'b0;
      pend_vga_q <= 1'b0;
      pay_err_q  <= '0;
      pay_cfg_q  <= '0;
      pay_vga_q  <= '0;
      drop_q     <= 8'd0;
    end else begin
      if (Error_Valid) begin
        pend_err_q <= 1'b1;
        pay_err_q  <= Config_Error;
      end else if (load_err) begin
        pend_err_q <= 1'b0;
      end
      if (Config_Notification_Valid) begin
        pend_cfg_q <= 1'b1;
        pay_cfg_q  <= Config_Notification;
      end else if (load_cfg) begin
        pend_cfg_q <= 1'b0;
      end
      if (VGA_Notification_Valid) begin
        pend_vga_q <= 1'b1;
        pay_vga_q  <= VGA_Notification;
      end else if (load_vga) begin
        pend_vga_q <= 1'b0;
      end
      drop_q <= (drop_next > 10'd255) ? 8'd255 : drop_next[7:0];
    end
  end

  assign TXD_Data   = txd_q;
  assign Wr_En      = (state_q == ST_SEND);
  assign Busy       = any_pend | (state_q == ST_SEND);
  assign Drop_Count = drop_q;

endmodule

// File: tb/tb_notification_tx_packer.sv
// tb/tb_notification_tx_packer.sv - self-checking bench for notification_tx_packer
module tb_notification_tx_packer;

  localparam int HB_P = 8;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic [3:0] Config_Notification;
  logic       Config_Notification_Valid;
  logic [3:0] Config_Error;
  logic       Error_Valid;
  logic [3:0] VGA_Notification;
  logic       VGA_Notification_Valid;
  logic [3:0] Config_Status;
  logic       Full;
  logic [7:0] TXD_Data;
  logic       Wr_En;
  logic       Busy;
  logic [7:0] Drop_Count;

  always #5 Clk = ~Clk;

  notification_tx_packer #(.HEARTBEAT_PERIOD(HB_P)) dut (
    .Clk                       (Clk),
    .rst_n                     (rst_n),
    .Config_Notification       (Config_Notification),
    .Config_Notification_Valid (Config_Notification_Valid),
    .Config_Error              (Config_Error),
    .Error_Valid               (Error_Valid),
    .VGA_Notification          (VGA_Notification),
    .VGA_Notification_Valid    (VGA_Notification_Valid),
    .Config_Status             (Config_Status),
    .Full                      (Full),
    .TXD_Data                  (TXD_Data),
    .Wr_En                     (Wr_En),
    .Busy                      (Busy),
    .Drop_Count                (Drop_Count)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int writes   = 0;

  // Reference model. Slot index 0 = error, 1 = config notification, 2 = VGA.
  // The slot index is also the priority order.
  logic       m_pend [3];
  logic [5:0] m_pay  [3];
  logic       m_send;
  logic [7:0] m_byte;
  int         m_drop;
`ifdef NOTIF_HEARTBEAT_EN
  int         m_idle;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input int s, input logic [5:0] p);
    logic [1:0] tag;
    tag = (s == 0) ? 2'b10 : (s == 1) ? 2'b01 : 2'b11;
    return {tag, p};
  endfunction

  task automatic model_edge();
    logic       v  [3];
    logic [5:0] in [3];
    logic       any;
    int         sel;
    v[0] = Error_Valid;               in[0] = 6'(Config_Error);
    v[1] = Config_Notification_Valid; in[1] = 6'(Config_Notification);
    v[2] = VGA_Notification_Valid;    in[2] = 6'(VGA_Notification);
    if (rst_n) begin
      for (int s = 0; s < 3; s++) begin
        m_pend[s] = 1'b0;
        m_pay[s]  = '0;
      end
      m_send = 1'b0;
      m_byte = 8'h00;
      m_drop = 0;
`ifdef NOTIF_HEARTBEAT_EN
      m_idle = 0;
`endif
    end else begin
      any = m_pend[0] | m_pend[1] | m_pend[2];
      sel = -1;
      if (m_send) begin
        if (!Full) m_send = 1'b0;
`ifdef NOTIF_HEARTBEAT_EN
        m_idle = 0;
`endif
      end else if (any) begin
        for (int s = 0; s < 3; s++) if (m_pend[s] && sel < 0) sel = s;
        m_byte      = pack(sel, m_pay[sel]);
        m_pend[sel] = 1'b0;
        m_send      = 1'b1;
`ifdef NOTIF_HEARTBEAT_EN
        m_idle = 0;
      end else if (m_idle == HB_P - 1) begin
        m_byte = {2'b00, 6'(Config_Status)};
        m_send = 1'b1;
        m_idle = 0;
      end else begin
        m_idle++;
`endif
      end
      for (int s = 0; s < 3; s++) begin
        if (v[s]) begin
          if (m_pend[s]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
          m_pend[s] = 1'b1;
          m_pay[s]  = in[s];
        end
      end
    end
  endtask

  task automatic step();
    if (Wr_En === 1'b1 && Full === 1'b0) writes++;
    @(posedge Clk);
    model_edge();
    #1;
    chk("m_wr_en", Wr_En, m_send);
    chk("m_txd", TXD_Data, m_byte);
    chk("m_busy", Busy, m_send | m_pend[0] | m_pend[1] | m_pend[2]);
    chk("m_drop", Drop_Count, m_drop);
  endtask

  task automatic clear_valids();
    Error_Valid               = 1'b0;
    Config_Notification_Valid = 1'b0;
    VGA_Notification_Valid    = 1'b0;
  endtask

  int w0;
  int last;

  initial begin
    rst_n = 1'b1;
    Full  = 1'b0;
    Config_Status       = 4'hA;
    Config_Notification = '0;
    Config_Error        = '0;
    VGA_Notification    = '0;
    clear_valids();
    step();
    chk("rst_wr_en", Wr_En, 1'b0);
    chk("rst_txd", TXD_Data, 8'h00);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_drop", Drop_Count, 8'd0);
    rst_n = 1'b0;

`ifndef NOTIF_HEARTBEAT_EN
    // One config notification pulse.
    Config_Notification = 4'h3; Config_Notification_Valid = 1'b1;
    step();
    clear_valids();
    chk("t1_wr_k", Wr_En, 1'b0);
    step();
    chk("t1_wr", Wr_En, 1'b1);
    chk("t1_txd", TXD_Data, 8'h43);
    step();
    chk("t1_wr_off", Wr_En, 1'b0);
    chk("t1_busy", Busy, 1'b0);

    // Simultaneous valids are sent in priority order.
    Config_Error = 4'h5; Config_Notification = 4'h2; VGA_Notification = 4'h9;
    Error_Valid = 1'b1; Config_Notification_Valid = 1'b1; VGA_Notification_Valid = 1'b1;
    step();
    clear_valids();
    step(); chk("t2_b0", TXD_Data, 8'h85); chk("t2_w0", Wr_En, 1'b1);
    step(); chk("t2_gap0", Wr_En, 1'b0);
    step(); chk("t2_b1", TXD_Data, 8'h42); chk("t2_w1", Wr_En, 1'b1);
    step(); chk("t2_gap1", Wr_En, 1'b0);
    step(); chk("t2_b2", TXD_Data, 8'hC9); chk("t2_w2", Wr_En, 1'b1);
    step(); chk("t2_end_busy", Busy, 1'b0);

    // Backpressure holds the byte stable.
    Config_Error = 4'h1; Error_Valid = 1'b1;
    step();
    clear_valids();
    Full = 1'b1;
    step();
    w0 = writes;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_wr", Wr_En, 1'b1);
      chk("t3_hold_txd", TXD_Data, 8'h81);
    end
    Full = 1'b0;
    step();
    chk("t3_wr_off", Wr_En, 1'b0);
    chk("t3_writes", writes - w0, 1);

    // Overwrite while pending: newest wins and one drop is counted.
    Full = 1'b1;
    Config_Error = 4'h2; Error_Valid = 1'b1;
    step();
    clear_valids();
    step();
    VGA_Notification = 4'h1; VGA_Notification_Valid = 1'b1;
    step();
    VGA_Notification = 4'h7;
    step();
    clear_valids();
    chk("t4_drop1", Drop_Count, 8'd1);
    Full = 1'b0;
    w0 = writes;
    step();
    step();
    chk("t4_vga_txd", TXD_Data, 8'hC7);
    for (int i = 0; i < 4; i++) step();
    chk("t4_writes", writes - w0, 2);
    chk("t4_idle", Busy, 1'b0);

    // Drop counter saturation.
    Full = 1'b1;
    Config_Error = 4'h3; Error_Valid = 1'b1;
    step();
    clear_valids();
    step();
    VGA_Notification_Valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      VGA_Notification = 4'($urandom);
      step();
    end
    clear_valids();
    chk("t4_sat", Drop_Count, 8'd255);

    // Reset during SEND with two slots pending.
    Config_Notification = 4'h4; Config_Notification_Valid = 1'b1;
    step();
    clear_valids();
    rst_n = 1'b1;
    step();
    chk("t5_wr", Wr_En, 1'b0);
    chk("t5_busy", Busy, 1'b0);
    chk("t5_drop", Drop_Count, 8'd0);
    rst_n = 1'b0;
    Full  = 1'b0;
    w0 = writes;
    for (int i = 0; i < 6; i++) step();
    chk("t5_no_send", writes - w0, 0);
`else
    // Heartbeat: 0x0A every HB_P idle edges plus one accept edge.
    last = -1;
    for (int i = 0; i < 40; i++) begin
      if (Wr_En === 1'b1) begin
        chk("hb_byte", TXD_Data, 8'h0A);
        if (last >= 0) chk("hb_gap", i - last, HB_P + 1);
        last = i;
      end
      step();
    end
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < HB_P - 2; i++) step();
    Config_Error = 4'h5; Error_Valid = 1'b1;
    step();
    clear_valids();
    step();
    chk("hb_err_first", TXD_Data, 8'h85);
    chk("hb_err_wr", Wr_En, 1'b1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      Error_Valid               = ($urandom % 4) == 0;
      Config_Notification_Valid = ($urandom % 4) == 0;
      VGA_Notification_Valid    = ($urandom % 4) == 0;
      Config_Error              = 4'($urandom);
      Config_Notification       = 4'($urandom);
      VGA_Notification          = 4'($urandom);
      Config_Status             = 4'($urandom);
      Full                      = ($urandom % 3) == 0;
      step();
    end
    clear_valids();
    Full = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
